vec_mul_seq_ctrl: RTL and testbench

Parametrised run sequencer for the vector-multiply datapath. On `start` it optionally loads a new weight set from the weight FIFO, streams `vec_count` input vectors out of the unified buffer, and writes each result into the result SRAM at a programmable base address. It tracks the datapath pipeline latency itself and signals completion with a `done` pulse. It sits between the top-level start logic and the UB / weight FIFO / vec_mul / result-SRAM instances, replacing the free-running counter and delay-flop sequencing used so far.

---
 rtl/vec_mul_pkg.sv | 17 +
 rtl/valid_pipe.sv | 35 +++
 rtl/vec_mul_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vec_mul_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mul_pkg.sv
// Shared types and default geometry for the vector-multiply datapath.
// The run sequencer and the top-level integration both import this package.
package vec_mul_pkg;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_PIPE_LAT    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WPOP,
        ST_WLATCH,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/valid_pipe.sv
// DEPTH-stage valid shift register: a 1 entering at in_valid leaves at
// out_valid exactly DEPTH cycles later.
module valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic in_valid,
    output logic out_valid,
    output logic empty,
    output logic empty_next
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = DEPTH'({stage_q, in_valid});
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid  = stage_q[DEPTH-1];
    assign empty      = ~|stage_q;
    // Only the tail (or nothing) is occupied: with no new input, empty after this edge.
    assign empty_next = ~|(stage_q << 1);

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// Run sequencer: optional weight load, vec_count UB reads, result writes
// delayed by the datapath latency, then a done pulse. All outputs registered.
module vec_mul_seq_ctrl
    import vec_mul_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   reload_weights,
    input  logic [ADDRESSSIZE:0]   vec_count,
    input  logic [ADDRESSSIZE-1:0] src_base,
    input  logic [ADDRESSSIZE-1:0] dst_base,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    typedef logic [ADDRESSSIZE-1:0] addr_t;
    typedef logic [ADDRESSSIZE:0]   cnt_t;

    seq_state_e state_q, state_d;
    cnt_t       vec_count_q, vec_count_d;
    addr_t      src_base_q, src_base_d;
    addr_t      dst_base_q, dst_base_d;
    cnt_t       issue_idx_q, issue_idx_d;
    cnt_t       wr_idx_q, wr_idx_d;

    logic       fifo_read_enable_q, fifo_read_enable_d;
    logic       weight_reload_q, weight_reload_d;
    addr_t      ub_address_q, ub_address_d;
    addr_t      res_address_q, res_address_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic       pipe_out;
    logic       pipe_empty;
    logic       pipe_empty_next;

    valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (state_q == ST_ISSUE),
        .out_valid  (pipe_out),
        .empty      (pipe_empty),
        .empty_next (pipe_empty_next)
    );

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        src_base_d  = src_base_q;
        dst_base_d  = dst_base_q;
        issue_idx_d = issue_idx_q;
        wr_idx_d    = wr_idx_q;
        error_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_count_d = vec_count;
                    src_base_d  = src_base;
                    dst_base_d  = dst_base;
                    issue_idx_d = '0;
                    wr_idx_d    = '0;
                    if (reload_weights && fifo_empty) begin
                        error_d = 1'b1;
                    end else if (reload_weights) begin
                        state_d = ST_WPOP;
                    end else if (vec_count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_WPOP:   state_d = ST_WLATCH;
            ST_WLATCH: state_d = (vec_count_q == '0) ? ST_FIN : ST_ISSUE;
            ST_ISSUE: begin
                issue_idx_d = issue_idx_q + cnt_t'(1);
                if (issue_idx_d == vec_count_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_next) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (pipe_out) begin
            wr_idx_d = wr_idx_q + cnt_t'(1);
        end

        // Outputs are registered from the next state so they line up with it.
        busy_d             = (state_d != ST_IDLE);
        done_d             = (state_d == ST_FIN);
        fifo_read_enable_d = (state_d == ST_WPOP);
        weight_reload_d    = (state_d == ST_WLATCH);
        ub_address_d       = (state_d == ST_ISSUE) ? src_base_d + addr_t'(issue_idx_d) : '0;
        res_address_d      = busy_d ? dst_base_d + addr_t'(wr_idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q            <= ST_IDLE;
            vec_count_q        <= '0;
            src_base_q         <= '0;
            dst_base_q         <= '0;
            issue_idx_q        <= '0;
            wr_idx_q           <= '0;
            fifo_read_enable_q <= 1'b0;
            weight_reload_q    <= 1'b0;
            ub_address_q       <= '0;
            res_address_q      <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            vec_count_q        <= vec_count_d;
            src_base_q         <= src_base_d;
            dst_base_q         <= dst_base_d;
            issue_idx_q        <= issue_idx_d;
            wr_idx_q           <= wr_idx_d;
            fifo_read_enable_q <= fifo_read_enable_d;
            weight_reload_q    <= weight_reload_d;
            ub_address_q       <= ub_address_d;
            res_address_q      <= res_address_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            error_q            <= error_d;
        end
    end

    // A run only returns to IDLE once the pipe has drained.
    idle_pipe_empty: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_IDLE) |-> pipe_empty);

    assign fifo_read_enable = fifo_read_enable_q;
    assign weight_reload    = weight_reload_q;
    assign ub_address       = ub_address_q;
    assign res_write_enable = pipe_out;
    assign res_address      = res_address_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Self-checking bench for vec_mul_seq_ctrl: scoreboard of expected UB reads
// and result writes, plus per-cycle control checks for each scenario.
module tb_vec_mul_seq_ctrl;

    localparam int A  = 10;
    localparam int P  = 2;
    localparam int WA = 4;
    localparam int WP = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         start, reload_weights, fifo_empty;
    logic [A:0]   vec_count;
    logic [A-1:0] src_base, dst_base;
    logic         fifo_read_enable, weight_reload, res_write_enable, busy, done, error;
    logic [A-1:0] ub_address, res_address;

    logic          w_start, w_reload, w_fifo_empty;
    logic [WA:0]   w_vec_count;
    logic [WA-1:0] w_src, w_dst;
    logic          w_fre, w_wrl, w_we, w_busy, w_done, w_error;
    logic [WA-1:0] w_ub, w_res;

    vec_mul_seq_ctrl #(.ADDRESSSIZE(A), .PIPE_LAT(P)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .reload_weights(reload_weights),
        .vec_count(vec_count), .src_base(src_base), .dst_base(dst_base),
        .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
        .weight_reload(weight_reload), .ub_address(ub_address),
        .res_write_enable(res_write_enable), .res_address(res_address),
        .busy(busy), .done(done), .error(error)
    );

    vec_mul_seq_ctrl #(.ADDRESSSIZE(WA), .PIPE_LAT(WP)) u_dut_wrap (
        .clk(clk), .rstn(rstn), .start(w_start), .reload_weights(w_reload),
        .vec_count(w_vec_count), .src_base(w_src), .dst_base(w_dst),
        .fifo_empty(w_fifo_empty), .fifo_read_enable(w_fre),
        .weight_reload(w_wrl), .ub_address(w_ub),
        .res_write_enable(w_we), .res_address(w_res),
        .busy(w_busy), .done(w_done), .error(w_error)
    );

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    ev_t ub_q[$], wr_q[$], w_ub_q[$], w_wr_q[$];
    ev_t mon_e, w_mon_e;

    int total = 0;
    int bad   = 0;
    int w_writes = 0;

    int s_cyc, d_cyc, end_cyc, fre_cyc, wrl_cyc, err_cyc;
    int poke_cyc = -1;
    bit no_ub;
    logic [A-1:0] ub_before;

    // Scoreboard for the main instance: UB reads at their expected cycles, every write popped.
    always @(negedge clk) begin
        if (ub_q.size() != 0 && ub_q[0].cyc == cyc) begin
            mon_e = ub_q.pop_front();
            total++;
            if (32'(ub_address) !== 32'(mon_e.addr)) begin
                bad++;
                $display("FAIL ub_address cyc=%0d got=%0d want=%0d", cyc, ub_address, mon_e.addr);
            end
        end
        if (res_write_enable === 1'b1) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d", cyc, res_address);
            end else begin
                mon_e = wr_q.pop_front();
                if (mon_e.cyc != cyc || 32'(res_address) !== 32'(mon_e.addr)) begin
                    bad++;
                    $display("FAIL write cyc=%0d addr=%0d want_cyc=%0d want_addr=%0d",
                             cyc, res_address, mon_e.cyc, mon_e.addr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (w_ub_q.size() != 0 && w_ub_q[0].cyc == cyc) begin
            w_mon_e = w_ub_q.pop_front();
            total++;
            if (32'(w_ub) !== 32'(w_mon_e.addr)) begin
                bad++;
                $display("FAIL wrap_ub_address cyc=%0d got=%0d want=%0d", cyc, w_ub, w_mon_e.addr);
            end
        end
        if (w_we === 1'b1) begin
            w_writes++;
            total++;
            if (w_wr_q.size() == 0) begin
                bad++;
                $display("FAIL wrap_unexpected_write cyc=%0d addr=%0d", cyc, w_res);
            end else begin
                w_mon_e = w_wr_q.pop_front();
                if (w_mon_e.cyc != cyc || 32'(w_res) !== 32'(w_mon_e.addr)) begin
                    bad++;
                    $display("FAIL wrap_write cyc=%0d addr=%0d want_cyc=%0d want_addr=%0d",
                             cyc, w_res, w_mon_e.cyc, w_mon_e.addr);
                end
            end
        end
    end

    // Drive one start pulse (start stays high until check_run's next cycle) and queue expectations.
    task automatic launch(input bit rw, input bit fe, input int n, input int src, input int dst);
        int first;
        @(posedge clk);
        #1;
        start          = 1'b1;
        reload_weights = rw;
        fifo_empty     = fe;
        vec_count      = n[A:0];
        src_base       = src[A-1:0];
        dst_base       = dst[A-1:0];
        s_cyc     = cyc;
        ub_before = ub_address;
        fre_cyc = -1; wrl_cyc = -1; err_cyc = -1; d_cyc = -1;
        no_ub   = (rw && fe) || (n == 0);
        if (rw && fe) begin
            err_cyc = s_cyc + 1;
            end_cyc = s_cyc + 3;
        end else begin
            first = rw ? s_cyc + 3 : s_cyc + 1;
            if (rw) begin
                fre_cyc = s_cyc + 1;
                wrl_cyc = s_cyc + 2;
            end
            d_cyc   = (n == 0) ? first : first + n + P;
            end_cyc = d_cyc;
            for (int k = 0; k < n; k++) begin
                ub_q.push_back('{first + k, (src + k) % (1 << A)});
                wr_q.push_back('{first + k + P, (dst + k) % (1 << A)});
            end
        end
    endtask

    // Step cycle by cycle from the start cycle, checking every control output.
    task automatic check_run(input int stop_cyc);
        int last;
        logic [4:0] got, want;
        last = (stop_cyc >= 0) ? stop_cyc : end_cyc;
        for (int c = s_cyc; c <= last; c++) begin
            if (c > s_cyc) begin
                start = (c == poke_cyc);
                if (c == poke_cyc) begin
                    reload_weights = 1'b1;
                    fifo_empty     = 1'b1;
                    vec_count      = 11'd7;
                    src_base       = 10'd1;
                    dst_base       = 10'd2;
                end
            end
            @(negedge clk);
            got  = {busy, done, error, fifo_read_enable, weight_reload};
            want = {(d_cyc >= 0) && (c > s_cyc) && (c <= d_cyc),
                    c == d_cyc, c == err_cyc, c == fre_cyc, c == wrl_cyc};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ctrl(busy,done,err,pop,latch) cyc=%0d got=%b want=%b", c, got, want);
            end
            if (no_ub) begin
                total++;
                if (ub_address !== ub_before) begin
                    bad++;
                    $display("FAIL ub_idle cyc=%0d got=%0d want=%0d", c, ub_address, ub_before);
                end
            end
            if (c < last) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        if (stop_cyc < 0) begin
            total++;
            if (ub_q.size() != 0 || wr_q.size() != 0) begin
                bad++;
                $display("FAIL missing_events ub_left=%0d wr_left=%0d want=0", ub_q.size(), wr_q.size());
            end
        end
    endtask

    task automatic test_reset();
        logic [2*A+5:0] got;
        rstn = 1'b1;
        start = 1'b0; reload_weights = 1'b0; fifo_empty = 1'b0;
        vec_count = '0; src_base = '0; dst_base = '0;
        w_start = 1'b0; w_reload = 1'b0; w_fifo_empty = 1'b0;
        w_vec_count = '0; w_src = '0; w_dst = '0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {fifo_read_enable, weight_reload, res_write_enable, busy, done, error, ub_address, res_address};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        rstn = 1'b1;
    endtask

    task automatic test_reload_run();
        launch(1'b1, 1'b0, 4, 10, 100);
        check_run(-1);
    endtask

    task automatic test_empty_fifo();
        launch(1'b1, 1'b1, 4, 10, 100);
        check_run(-1);
    endtask

    task automatic test_zero_len();
        launch(1'b0, 1'b1, 0, 33, 44);
        check_run(-1);
        launch(1'b1, 1'b0, 0, 55, 66);
        check_run(-1);
    endtask

    task automatic test_busy_then_back_to_back();
        launch(1'b0, 1'b0, 3, 200, 300);
        poke_cyc = s_cyc + 4;
        check_run(-1);
        poke_cyc = -1;
        launch(1'b1, 1'b0, 2, 1020, 1022);
        check_run(-1);
    endtask

    task automatic test_reset_mid_stream();
        logic [2*A+5:0] got;
        launch(1'b0, 1'b0, 20, 5, 50);
        check_run(s_cyc + 6);
        #2 rstn = 1'b0;
        #1;
        got = {fifo_read_enable, weight_reload, res_write_enable, busy, done, error, ub_address, res_address};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_mid_run got=%h want=0", got);
        end
        ub_q.delete();
        wr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = {fifo_read_enable, weight_reload, res_write_enable, busy, done, error, ub_address, res_address};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_held got=%h want=0", got);
        end
        rstn = 1'b1;
        launch(1'b0, 1'b0, 3, 7, 70);
        check_run(-1);
    endtask

    task automatic test_wrap();
        int s;
        int found;
        @(posedge clk);
        #1;
        w_start = 1'b1; w_reload = 1'b0; w_fifo_empty = 1'b0;
        w_vec_count = 5'd16; w_src = 4'd14; w_dst = 4'd15;
        s = cyc;
        w_writes = 0;
        for (int k = 0; k < 16; k++) begin
            w_ub_q.push_back('{s + 1 + k, (14 + k) % 16});
            w_wr_q.push_back('{s + 1 + k + WP, (15 + k) % 16});
        end
        @(posedge clk);
        #1;
        w_start = 1'b0;
        found = -1;
        for (int i = 0; i < 40 && found < 0; i++) begin
            @(negedge clk);
            if (w_done === 1'b1) found = cyc;
        end
        total++;
        if (found != s + 1 + 16 + WP) begin
            bad++;
            $display("FAIL wrap_done cyc=%0d want=%0d", found, s + 1 + 16 + WP);
        end
        total++;
        if (w_writes != 16 || w_ub_q.size() != 0 || w_wr_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_count writes=%0d want=16 ub_left=%0d wr_left=%0d",
                     w_writes, w_ub_q.size(), w_wr_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want=finish", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reload_run();
        test_empty_fifo();
        test_zero_len();
        test_busy_then_back_to_back();
        test_reset_mid_stream();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
